// File: rtl/rotate_pkg.sv
// rotate_pkg: shared constants, direction codes and FSM states for the rotate datapath.
package rotate_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHIFT_W = 5;
  localparam logic ROT_LEFT = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rotate_unit.sv
// rotate_unit: registered left/right rotator, result valid one cycle after en.
module rotate_unit import rotate_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dir,
  output logic [WIDTH-1:0]   result
);
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  // The doubled word makes shift 0 fall out naturally without a WIDTH-bit shift.
  always_comb begin
    result_d = WIDTH'(dir == ROT_RIGHT ? {data, data} >> shift : ({data, data} << shift) >> WIDTH);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) result_q <= '0;
    else if (en) result_q <= result_d;
  end
  assign result = result_q;
endmodule

// File: rtl/rotate_sched.sv
// rotate_sched: round-robin share of one rotate unit between two requesters.
// Define ROTATE_SCHED_STATS_EN to add saturating per-requester grant counters.
module rotate_sched import rotate_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_data0,
  input  logic [SHIFT_W-1:0] req_shift0,
  input  logic               req_dir0,
  input  logic [WIDTH-1:0]   req_data1,
  input  logic [SHIFT_W-1:0] req_shift1,
  input  logic               req_dir1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
`ifdef ROTATE_SCHED_STATS_EN
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
`endif
  output logic               rsp_id
);
  state_e state_q;
  logic last_q, id_q, rsp_valid_q, dir_q, grant, accept;
  logic [WIDTH-1:0] data_q;
  logic [SHIFT_W-1:0] shift_q;
  // req_ready is gated by reset_n so nothing looks accepted while held in reset.
  always_comb begin
    grant = &req_valid ? ~last_q : req_valid[1];
    accept = reset_n && state_q == IDLE && |req_valid;
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q <= '0;
      shift_q <= '0;
      dir_q <= ROT_LEFT;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= EXEC;
          last_q <= grant;
          id_q <= grant;
          data_q <= grant ? req_data1 : req_data0;
          shift_q <= grant ? req_shift1 : req_shift0;
          dir_q <= grant ? req_dir1 : req_dir0;
        end
        EXEC: begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  rotate_unit #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) u_rot (
    .clk(clk),
    .reset_n(reset_n),
    .en(state_q == EXEC),
    .data(data_q),
    .shift(shift_q),
    .dir(dir_q),
    .result(rsp_data)
  );
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = id_q;
`ifdef ROTATE_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (!grant && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (grant && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_rotate_sched.sv
// tb_rotate_sched: directed and randomized checks of rotate_sched against a behavioural model.
module tb_rotate_sched;
  logic clk = 0, reset_n = 0, rsp_ready = 1;
  logic [1:0] req_valid = 2'b11, req_ready;
  logic [31:0] req_data0 = 0, req_data1 = 0, rsp_data;
  logic [4:0] req_shift0 = 0, req_shift1 = 0;
  logic req_dir0 = 0, req_dir1 = 0, rsp_valid, rsp_id;
`ifdef ROTATE_SCHED_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif
  always #5 clk = ~clk;

  rotate_sched dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_shift0(req_shift0), .req_dir0(req_dir0),
    .req_data1(req_data1), .req_shift1(req_shift1), .req_dir1(req_dir1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ROTATE_SCHED_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .rsp_id(rsp_id)
  );

  int compared = 0, mismatched = 0, cyc = 0, acc_cyc = 0, cnt0 = 0, cnt1 = 0;
  bit busy = 0;
  logic last_g = 1, exp_id = 0;
  logic [31:0] exp_data = 0;
  logic [1:0] acc_seen = 0;
  logic dut_ids[$];

  function automatic logic [31:0] rot_ref(logic [31:0] d, int s, logic dir);
    for (int i = 0; i < s; i++) d = dir ? {d[0], d[31:1]} : {d[30:0], d[31]};
    return d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: one op in flight, arbitration by alternation, response two samples after accept.
  always @(negedge clk) begin
    logic g;
    logic [1:0] er;
    cyc++;
    if (!reset_n) begin
      busy = 0; last_g = 1; cnt0 = 0; cnt1 = 0; acc_seen = 0;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_id", rsp_id, 0);
    end else begin
      g = (req_valid == 2'b11) ? ~last_g : req_valid[1];
      er = (!busy && req_valid != 0) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, busy && cyc >= acc_cyc + 2);
      if (rsp_valid && busy) begin
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_id", rsp_id, exp_id);
      end
      acc_seen = req_valid & req_ready;
      if (rsp_valid && rsp_ready) dut_ids.push_back(rsp_id);
      if (rsp_valid && rsp_ready && busy && cyc >= acc_cyc + 2) busy = 0;
      if (er != 0) begin
        busy = 1; acc_cyc = cyc; last_g = g; exp_id = g;
        exp_data = g ? rot_ref(req_data1, req_shift1, req_dir1) : rot_ref(req_data0, req_shift0, req_dir0);
        if (g) cnt1++; else cnt0++;
      end
    end
`ifdef ROTATE_SCHED_STATS_EN
    chk("grant_cnt0", grant_cnt0, 32'(cnt0));
    chk("grant_cnt1", grant_cnt1, 32'(cnt1));
`endif
  end

  task automatic set_req(input int r, input logic v, input logic [31:0] d, input logic [4:0] s, input logic dir);
    if (r == 0) begin req_valid[0] = v; req_data0 = d; req_shift0 = s; req_dir0 = dir; end
    else begin req_valid[1] = v; req_data1 = d; req_shift1 = s; req_dir1 = dir; end
  endtask

  task automatic wait_accept(input int r);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = acc_seen[r];
    end
    chk("accept_timeout", 32'(ok), 1);
  endtask

  task automatic do_op(input int r, input logic [31:0] d, input logic [4:0] s, input logic dir,
                       input logic [31:0] exp, input logic eid, input string name);
    int k;
    set_req(r, 1, d, s, dir);
    wait_accept(r);
    req_valid[r] = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk({name, "_latency"}, k, 1);
    chk({name, "_data"}, rsp_data, exp);
    chk({name, "_id"}, rsp_id, eid);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(negedge clk);
    chk("rst_hold_ready", req_ready, 0);
    chk("rst_hold_data", rsp_data, 0);
    @(posedge clk); #1;
    reset_n = 1;
    set_req(0, 1, 32'h0000_00F0, 5'd4, 1'b1);
    set_req(1, 1, 32'h8000_0001, 5'd3, 1'b0);
    dut_ids.delete();
    for (int k = 0; k < 60 && dut_ids.size() < 4; k++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++)
        if (acc_seen[r]) set_req(r, 1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    req_valid = 0;
    chk("contend_count", dut_ids.size(), 4);
    for (int i = 0; i < 4 && i < dut_ids.size(); i++) chk("contend_id", 32'(dut_ids[i]), 32'(i % 2));
    repeat (3) @(posedge clk); #1;
    do_op(0, 32'h0000_0001, 5'd4, 1'b0, 32'h0000_0010, 1'b0, "left4");
    do_op(1, 32'h0000_0001, 5'd1, 1'b1, 32'h8000_0000, 1'b1, "right_wrap");
    do_op(1, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, "right0");
    do_op(0, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, "left0");
    do_op(0, 32'h8000_0000, 5'd31, 1'b0, 32'h4000_0000, 1'b0, "left31");
    rsp_ready = 0;
    set_req(0, 1, 32'h1234_5678, 5'd8, 1'b0);
    wait_accept(0);
    req_valid[0] = 0;
    set_req(1, 1, 32'h0000_FFFF, 5'd16, 1'b1);
    repeat (2) @(negedge clk);
    held = rsp_data;
    chk("bp_data", held, 32'h3456_7812);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_hold", rsp_data, held);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    wait_accept(1);
    req_valid[1] = 0;
    repeat (4) @(posedge clk); #1;
    set_req(0, 1, 32'hCAFE_F00D, 5'd7, 1'b1);
    wait_accept(0);
    reset_n = 0;
    req_valid = 0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_quiet", rsp_valid, 0);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (acc_seen[r] || (req_valid[r] && $urandom_range(0, 15) == 0)) req_valid[r] = 0;
        else if (!req_valid[r] && $urandom_range(0, 2) == 0)
          set_req(r, 1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    req_valid = 0;
    rsp_ready = 1;
    repeat (6) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
